// File: rtl/systolic_pkg.sv
// Shared FSM encodings and elaboration-time helpers for the output-stationary systolic MAC array.
package systolic_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Zero-operand advances needed for the far corner PE to see the last beat.
  function automatic int flush_cycles(input int n);
    return 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: multiply-accumulate on advance, with A forwarded right and B forwarded down.
module systolic_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  clr_acc_i,
  input  logic                  clr_pipe_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   a_q, b_q;

  generate
    if (SIGNED != 0) begin : g_signed
      assign prod     = (2*DATA_WIDTH)'($signed(a_i)) * (2*DATA_WIDTH)'($signed(b_i));
      assign prod_ext = ACC_WIDTH'($signed(prod));
    end else begin : g_unsigned
      assign prod     = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
      assign prod_ext = ACC_WIDTH'(prod);
    end
  endgenerate

  // Wraps modulo 2^ACC_WIDTH by construction.
  assign acc_d = acc_q + prod_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      if (clr_acc_i) begin
        acc_q <= '0;
      end else if (en_i) begin
        acc_q <= acc_d;
      end
      if (clr_pipe_i) begin
        a_q <= '0;
        b_q <= '0;
      end else if (en_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_array.sv
// N x N output-stationary matrix-multiply array: input skew, load/flush/drain sequencing, row-wise result stream.
module systolic_mm_array
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int K_WIDTH    = 8,
  parameter int SIGNED     = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [K_WIDTH-1:0]                 k_len,
  input  logic                               accumulate,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   in_left,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   in_top,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]    out_row,
  output logic [clog2_min1(ARRAY_SIZE)-1:0]  out_row_idx,
  output logic                               busy,
  output logic                               done
);

  localparam int N     = ARRAY_SIZE;
  localparam int FC    = flush_cycles(ARRAY_SIZE);
  localparam int FW    = clog2_min1(FC + 1);
  localparam int IDX_W = clog2_min1(ARRAY_SIZE);

  logic [1:0]         state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [K_WIDTH-1:0] beat_q, beat_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic               done_q, done_d;
  logic               clr_acc, clr_pipe, adv, load_sel;

  logic [DATA_WIDTH-1:0] skew_a [N];
  logic [DATA_WIDTH-1:0] skew_b [N];
  logic [DATA_WIDTH-1:0] a_pass [N][N];
  logic [DATA_WIDTH-1:0] b_pass [N][N];
  logic [ACC_WIDTH-1:0]  acc    [N][N];

  assign load_sel = (state_q == ST_LOAD);
  // The whole grid steps together, so a stalled beat never breaks the diagonal wavefront.
  assign adv      = (load_sel && in_valid) || (state_q == ST_FLUSH);

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    beat_d   = beat_q;
    flush_d  = flush_q;
    row_d    = row_q;
    done_d   = 1'b0;
    clr_acc  = 1'b0;
    clr_pipe = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d  = k_len;
          beat_d   = '0;
          flush_d  = '0;
          row_d    = '0;
          clr_pipe = 1'b1;
          clr_acc  = ~accumulate;
          state_d  = (k_len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (beat_q == k_len_q - K_WIDTH'(1)) begin
            beat_d  = '0;
            state_d = (FC == 0) ? ST_DRAIN : ST_FLUSH;
          end else begin
            beat_d = beat_q + K_WIDTH'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FW'(FC - 1)) begin
          flush_d = '0;
          state_d = ST_DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_q == IDX_W'(N - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_skew
      logic [DATA_WIDTH-1:0] a_feed, b_feed;
      // Operands outside LOAD are forced to zero so flushing never injects stale bus values.
      assign a_feed = load_sel ? in_left[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign b_feed = load_sel ? in_top[gi*DATA_WIDTH +: DATA_WIDTH]  : '0;
      if (gi == 0) begin : g_nodly
        assign skew_a[gi] = a_feed;
        assign skew_b[gi] = b_feed;
      end else begin : g_dly
        logic [DATA_WIDTH-1:0] a_sr_q [gi];
        logic [DATA_WIDTH-1:0] b_sr_q [gi];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int k = 0; k < gi; k++) begin
              a_sr_q[k] <= '0;
              b_sr_q[k] <= '0;
            end
          end else if (clr_pipe) begin
            for (int k = 0; k < gi; k++) begin
              a_sr_q[k] <= '0;
              b_sr_q[k] <= '0;
            end
          end else if (adv) begin
            a_sr_q[0] <= a_feed;
            b_sr_q[0] <= b_feed;
            for (int k = 1; k < gi; k++) begin
              a_sr_q[k] <= a_sr_q[k-1];
              b_sr_q[k] <= b_sr_q[k-1];
            end
          end
        end
        assign skew_a[gi] = a_sr_q[gi-1];
        assign skew_b[gi] = b_sr_q[gi-1];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        logic [DATA_WIDTH-1:0] a_in, b_in;
        if (gj == 0) begin : g_a_edge
          assign a_in = skew_a[gi];
        end else begin : g_a_int
          assign a_in = a_pass[gi][gj-1];
        end
        if (gi == 0) begin : g_b_edge
          assign b_in = skew_b[gj];
        end else begin : g_b_int
          assign b_in = b_pass[gi-1][gj];
        end
        systolic_pe #(
          .DATA_WIDTH (DATA_WIDTH),
          .ACC_WIDTH  (ACC_WIDTH),
          .SIGNED     (SIGNED)
        ) u_pe (
          .clk        (clk),
          .reset      (reset),
          .en_i       (adv),
          .clr_acc_i  (clr_acc),
          .clr_pipe_i (clr_pipe),
          .a_i        (a_in),
          .b_i        (b_in),
          .a_o        (a_pass[gi][gj]),
          .b_o        (b_pass[gi][gj]),
          .acc_o      (acc[gi][gj])
        );
      end
    end
  endgenerate

  always_comb begin
    out_row = '0;
    if (state_q == ST_DRAIN) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
      end
    end
  end

  assign in_ready    = load_sel;
  assign out_valid   = (state_q == ST_DRAIN);
  assign out_row_idx = row_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_mm_array.sv
// Directed plus randomized passes on an unsigned and a signed array, checked against a matrix-product model.
module tb_systolic_mm_array;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int KW = 8;
  localparam int RW = N * AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_u, start_s, accumulate, in_valid, out_ready;
  logic [KW-1:0] k_len;
  logic [N*DW-1:0] in_left, in_top;

  logic          in_ready_u, out_valid_u, busy_u, done_u;
  logic [RW-1:0] out_row_u;
  logic [1:0]    out_row_idx_u;
  logic          in_ready_s, out_valid_s, busy_s, done_s;
  logic [RW-1:0] out_row_s;
  logic [1:0]    out_row_idx_s;

  systolic_mm_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .start(start_u), .k_len(k_len), .accumulate(accumulate),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_left(in_left), .in_top(in_top),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_row(out_row_u),
    .out_row_idx(out_row_idx_u), .busy(busy_u), .done(done_u)
  );

  systolic_mm_array #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .k_len(k_len), .accumulate(accumulate),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_left(in_left), .in_top(in_top),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_row(out_row_s),
    .out_row_idx(out_row_idx_s), .busy(busy_s), .done(done_s)
  );

  int sel = 0;
  logic          in_ready_m, out_valid_m, busy_m, done_m;
  logic [RW-1:0] out_row_m;
  logic [1:0]    out_row_idx_m;
  assign in_ready_m    = (sel != 0) ? in_ready_s    : in_ready_u;
  assign out_valid_m   = (sel != 0) ? out_valid_s   : out_valid_u;
  assign busy_m        = (sel != 0) ? busy_s        : busy_u;
  assign done_m        = (sel != 0) ? done_s        : done_u;
  assign out_row_m     = (sel != 0) ? out_row_s     : out_row_u;
  assign out_row_idx_m = (sel != 0) ? out_row_idx_s : out_row_idx_u;

  logic [DW-1:0] mat_a [N][64];
  logic [DW-1:0] mat_b [64][N];
  longint        model_c [2][N][N];
  int            passed = 0;
  int            total  = 0;
  logic [RW-1:0] first_row, last_row;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] row_of4(input int e0, input int e1, input int e2, input int e3);
    logic [RW-1:0] v;
    v = '0;
    v[0*AW +: AW] = AW'(e0);
    v[1*AW +: AW] = AW'(e1);
    v[2*AW +: AW] = AW'(e2);
    v[3*AW +: AW] = AW'(e3);
    return v;
  endfunction

  function automatic logic [RW-1:0] exp_row(input int s, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = AW'(model_c[s][r][j]);
    return v;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) model_c[s][r][j] = 0;
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = DW'(i + 1);
        mat_b[k][i] = DW'(i + 1);
      end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = av;
        mat_b[k][i] = bv;
      end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < N; i++) begin
        mat_a[i][k] = DW'($urandom);
        mat_b[k][i] = DW'($urandom);
      end
  endtask

  task automatic drive_beat(input int b, input bit v);
    for (int i = 0; i < N; i++) begin
      in_left[i*DW +: DW] = v ? mat_a[i][b] : DW'($urandom);
      in_top[i*DW +: DW]  = v ? mat_b[b][i] : DW'($urandom);
    end
  endtask

  task automatic run_pass(input string name, input int s, input int k, input bit acc,
                          input int gap_mode, input int stall_row, input int stall_len,
                          input bit busy_start);
    int b, guard, w;
    bit v, rdy;
    longint pa, pb;
    sel = s;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        if (!acc) model_c[s][r][j] = 0;
        for (int kk = 0; kk < k; kk++) begin
          if (s != 0) begin
            pa = longint'($signed(mat_a[r][kk]));
            pb = longint'($signed(mat_b[kk][j]));
          end else begin
            pa = longint'(mat_a[r][kk]);
            pb = longint'(mat_b[kk][j]);
          end
          model_c[s][r][j] += pa * pb;
        end
      end

    @(negedge clk);
    if (s != 0) start_s = 1'b1; else start_u = 1'b1;
    k_len = KW'(k);
    accumulate = acc;
    @(negedge clk);
    start_s = 1'b0;
    start_u = 1'b0;
    k_len = KW'($urandom);
    accumulate = 1'($urandom);
    check({name, "_busy_start"}, busy_m, 1);

    if (k > 0) begin
      check({name, "_in_ready_load"}, in_ready_m, 1);
      b = 0;
      guard = 0;
      while (b < k && guard < 500) begin
        if (gap_mode == 0)      v = 1'b1;
        else if (gap_mode == 1) v = (guard % 2 == 0);
        else                    v = 1'($urandom_range(0, 1));
        in_valid = v;
        drive_beat(b, v);
        if (busy_start && b == 1) begin
          if (s != 0) start_s = 1'b1; else start_u = 1'b1;
          k_len = KW'(9);
          accumulate = 1'b1;
        end
        rdy = in_ready_m;
        @(negedge clk);
        start_s = 1'b0;
        start_u = 1'b0;
        if (v && rdy) b++;
        guard++;
      end
      in_valid = 1'b0;
      drive_beat(0, 1'b0);
      check({name, "_beats"}, b, k);
      check({name, "_in_ready_flush"}, in_ready_m, 0);
      w = 0;
      while (!out_valid_m && w < 100) begin
        @(negedge clk);
        w++;
      end
      check({name, "_flush_latency"}, w, 2 * N - 2);
    end else begin
      check({name, "_k0_drain"}, out_valid_m, 1);
    end

    for (int r = 0; r < N; r++) begin
      w = 0;
      while (!out_valid_m && w < 100) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("%s_valid_r%0d", name, r), out_valid_m, 1);
      check($sformatf("%s_idx_r%0d", name, r), out_row_idx_m, r);
      check($sformatf("%s_row_r%0d", name, r), out_row_m, exp_row(s, r));
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (stall_len) @(negedge clk);
        check($sformatf("%s_stall_valid_r%0d", name, r), out_valid_m, 1);
        check($sformatf("%s_stall_idx_r%0d", name, r), out_row_idx_m, r);
        check($sformatf("%s_stall_row_r%0d", name, r), out_row_m, exp_row(s, r));
      end
      if (r == 0) first_row = out_row_m;
      last_row = out_row_m;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (r < N - 1) check($sformatf("%s_no_done_r%0d", name, r), done_m, 0);
    end
    check({name, "_done"}, done_m, 1);
    check({name, "_idle_busy"}, busy_m, 0);
    check({name, "_idle_valid"}, out_valid_m, 0);
    @(negedge clk);
    check({name, "_done_once"}, done_m, 0);
  endtask

  initial begin
    reset = 1'b1;
    start_u = 1'b0;
    start_s = 1'b0;
    accumulate = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    k_len = '0;
    in_left = '0;
    in_top = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_busy", busy_u, 0);
    check("rst_in_ready", in_ready_u, 0);
    check("rst_out_valid", out_valid_u, 0);
    check("rst_out_row", out_row_u, 0);
    check("rst_done", done_u, 0);
    check("rst_s_busy", busy_s, 0);
    reset = 1'b0;

    // Test 1: abort a pass mid-LOAD with reset.
    sel = 0;
    fill_ramp();
    @(negedge clk);
    start_u = 1'b1;
    k_len = KW'(4);
    @(negedge clk);
    start_u = 1'b0;
    in_valid = 1'b1;
    drive_beat(0, 1'b1);
    @(negedge clk);
    drive_beat(1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_busy", busy_u, 0);
    check("midrst_in_ready", in_ready_u, 0);
    check("midrst_out_valid", out_valid_u, 0);
    check("midrst_out_row", out_row_u, 0);
    check("midrst_done", done_u, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    // Test 2: basic 4-beat pass.
    run_pass("t2", 0, 4, 1'b0, 0, -1, 0, 1'b0);
    check("t2_row0_const", first_row, row_of4(4, 8, 12, 16));
    check("t2_row3_const", last_row, row_of4(16, 32, 48, 64));

    // Test 3: toggling in_valid and a 3-cycle stall on row 1.
    run_pass("t3", 0, 4, 1'b0, 1, 1, 3, 1'b0);
    check("t3_row0_const", first_row, row_of4(4, 8, 12, 16));

    // Test 4: accumulate across passes, then clear again.
    run_pass("t4a", 0, 4, 1'b1, 0, -1, 0, 1'b0);
    check("t4a_row0_const", first_row, row_of4(8, 16, 24, 32));
    run_pass("t4b", 0, 4, 1'b0, 0, -1, 0, 1'b0);
    check("t4b_row0_const", first_row, row_of4(4, 8, 12, 16));

    // Test 5: accumulator wrap.
    fill_const(8'hFF, 8'hFF);
    run_pass("t5", 0, 17, 1'b0, 0, -1, 0, 1'b0);
    check("t5_wrap_const", last_row, row_of4(56849, 56849, 56849, 56849));

    // Test 6: signed operands, a start pulse while busy, then an empty pass.
    fill_const(8'hFF, 8'h03);
    run_pass("t6a", 1, 2, 1'b0, 0, -1, 0, 1'b1);
    check("t6a_neg_const", last_row, row_of4(20'hFFFFA, 20'hFFFFA, 20'hFFFFA, 20'hFFFFA));
    run_pass("t6b", 1, 0, 1'b0, 0, -1, 0, 1'b0);
    check("t6b_zero_const", first_row, '0);

    // Randomized passes on both flavours.
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      run_pass($sformatf("rnd_u%0d", t), 0, $urandom_range(1, 20), 1'($urandom_range(0, 1)),
               2, $urandom_range(0, N - 1), $urandom_range(1, 4), 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      run_pass($sformatf("rnd_s%0d", t), 1, $urandom_range(1, 20), 1'($urandom_range(0, 1)),
               2, $urandom_range(0, N - 1), $urandom_range(1, 4), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
